// File: rtl/emu_scan_pkg.sv
// Shared definitions for the emulator scan controller.
//   - default parameter widths
//   - scan command op encodings (save / load)
//   - controller state enumeration
package emu_scan_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  localparam logic OP_SAVE = 1'b0;  // scan chain contents out to the host
  localparam logic OP_LOAD = 1'b1;  // scan host data into the chain

  // Encodings are fixed so existing waveform decoders keep working.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_FF    = 3'd2,
    ST_GAP   = 3'd3,
    ST_RAM   = 3'd4,
    ST_FIN   = 3'd5
  } scan_state_e;

endpackage

// File: rtl/scan_word_cnt.sv
// Loadable word down-counter shared by the FF and RAM scan phases.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   load/load_val : load a new word count (has priority over dec)
//   dec           : decrement by one word; saturates at zero
//   count         : current remaining words
//   last          : count == 1, i.e. the next decrement finishes the phase
module scan_word_cnt #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 last
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CntOne;
    end
  end

  assign last = (count == CntOne);

endmodule

// File: rtl/emu_scan_ctrl.sv
// Emulator scan controller: pauses the emulated DUT, then streams the FF
// chain and the RAM chain out (save) or in (load), one word per handshake.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   run_en, dut_stall                : host run request, memory-model stall
//   cmd_valid/cmd_ready, cmd_op,
//   cmd_ff_words, cmd_ram_words      : scan command
//   s_valid/s_ready/s_data           : load stream from the host
//   m_valid/m_ready/m_data           : save stream to the host
//   ff_sdo/ff_sdi, ram_sdo/ram_sdi   : chain data out / in
//   pause, ff_scan, ff_dir,
//   ram_scan, ram_dir                : chain control
//   dut_clk_en, ff_clk_en, ram_clk_en: clock gate enables
//   busy, done                       : status; done pulses for one cycle
module emu_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_en,
  input  logic                  dut_stall,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_ff_words,
  input  logic [CNT_WIDTH-1:0]  cmd_ram_words,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic [DATA_WIDTH-1:0] ff_sdo,
  input  logic [DATA_WIDTH-1:0] ram_sdo,
  output logic [DATA_WIDTH-1:0] ff_sdi,
  output logic [DATA_WIDTH-1:0] ram_sdi,
  output logic                  pause,
  output logic                  ff_scan,
  output logic                  ff_dir,
  output logic                  ram_scan,
  output logic                  ram_dir,
  output logic                  dut_clk_en,
  output logic                  ff_clk_en,
  output logic                  ram_clk_en,
  output logic                  busy,
  output logic                  done
);

  scan_state_e          state_q, state_d;
  logic                 op_q;
  logic [CNT_WIDTH-1:0] ram_words_q;
  logic                 pause_q;

  logic                 cnt_load;
  logic [CNT_WIDTH-1:0] cnt_load_val;
  logic                 cnt_dec;
  logic [CNT_WIDTH-1:0] cnt_count;
  logic                 cnt_last;

  logic in_idle, in_ff, in_ram, in_scan, shift;

  assign in_idle = (state_q == ST_IDLE);
  assign in_ff   = (state_q == ST_FF);
  assign in_ram  = (state_q == ST_RAM);
  assign in_scan = in_ff || in_ram;

  // One counter serves both phases: FF length is loaded on command
  // acceptance, the latched RAM length when the RAM phase starts.
  scan_word_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_word_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .count   (cnt_count),
    .last    (cnt_last)
  );

  // Stream and chain datapath.
  always_comb begin
    m_valid = in_scan && (op_q == OP_SAVE);
    s_ready = in_scan && (op_q == OP_LOAD);
    shift   = (m_valid && m_ready) || (s_valid && s_ready);
    m_data  = in_ff ? ff_sdo : (in_ram ? ram_sdo : '0);
    // Saving recirculates the chain so its contents survive the scan.
    ff_sdi  = (in_ff && (op_q == OP_LOAD)) ? s_data : ff_sdo;
    ram_sdi = (in_ram && (op_q == OP_LOAD)) ? s_data : ram_sdo;
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = cmd_ff_words;
    cnt_dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_DRAIN;
          cnt_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_count != '0) begin
          state_d = ST_FF;
        end else if (ram_words_q != '0) begin
          state_d      = ST_RAM;
          cnt_load     = 1'b1;
          cnt_load_val = ram_words_q;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FF: begin
        if (shift) begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (ram_words_q != '0) begin
          state_d      = ST_RAM;
          cnt_load     = 1'b1;
          cnt_load_val = ram_words_q;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_RAM: begin
        if (shift) begin
          cnt_dec = 1'b1;
          if (cnt_last) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SAVE;
      ram_words_q <= '0;
      pause_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      // Looking at state_d makes pause rise with DRAIN and fall right after FIN.
      pause_q <= (state_d != ST_IDLE) || !run_en;
      if (in_idle && cmd_valid) begin
        op_q        <= cmd_op;
        ram_words_q <= cmd_ram_words;
      end
    end
  end

  // Control outputs.
  always_comb begin
    cmd_ready  = in_idle;
    busy       = !in_idle;
    done       = (state_q == ST_FIN);
    pause      = pause_q;
    ff_scan    = in_ff;
    ff_dir     = in_ff && op_q;
    ram_scan   = in_ram;
    ram_dir    = in_ram && op_q;
    dut_clk_en = in_idle && !pause_q && !dut_stall;
    ff_clk_en  = in_idle ? dut_clk_en : (in_ff && shift);
    ram_clk_en = in_idle ? dut_clk_en : (in_ram && shift);
  end

endmodule

// File: tb/tb_emu_scan_ctrl.sv
module tb_emu_scan_ctrl;

  localparam int DW = 64;
  localparam int CW = 16;

  localparam int EV_FF   = 1;
  localparam int EV_RAM  = 2;
  localparam int EV_DONE = 3;

  localparam logic [63:0] FF_WORD  = 64'hF0F0_1234_5678_0001;
  localparam logic [63:0] RAM_WORD = 64'hA5A5_9ABC_DEF0_0002;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_en = 1'b0, dut_stall = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [CW-1:0] cmd_ff_words = '0, cmd_ram_words = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [DW-1:0] ff_sdo = FF_WORD, ram_sdo = RAM_WORD, ff_sdi, ram_sdi;
  logic          pause, ff_scan, ff_dir, ram_scan, ram_dir;
  logic          dut_clk_en, ff_clk_en, ram_clk_en, busy, done;

  typedef struct {
    int          kind;
    logic        dir;
    logic [63:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] ld_words[8];

  emu_scan_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .dut_stall(dut_stall),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ff_words(cmd_ff_words), .cmd_ram_words(cmd_ram_words),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ff_sdo(ff_sdo), .ram_sdo(ram_sdo), .ff_sdi(ff_sdi), .ram_sdi(ram_sdi),
    .pause(pause), .ff_scan(ff_scan), .ff_dir(ff_dir),
    .ram_scan(ram_scan), .ram_dir(ram_dir),
    .dut_clk_en(dut_clk_en), .ff_clk_en(ff_clk_en), .ram_clk_en(ram_clk_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic dir, input logic [63:0] data);
    ev_t e;
    e.kind = kind;
    e.dir  = dir;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sb_take(input int kind, input logic dir, input logic [63:0] data,
                         input logic hs);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected: got event kind %0d want none", kind);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 64'(kind), 64'(e.kind));
      check("sb_dir", 64'(dir), 64'(e.dir));
      check("sb_data", data, e.data);
      // A chain clock during a scan must coincide with a stream handshake.
      if (kind != EV_DONE) check("sb_handshake", 64'(hs), 64'd1);
    end
  endtask

  // Monitor: every chain shift or done pulse while busy is scored in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && ff_clk_en)
        sb_take(EV_FF, ff_dir, m_valid ? m_data : ff_sdi,
                (m_valid && m_ready) || (s_valid && s_ready));
      if (busy && ram_clk_en)
        sb_take(EV_RAM, ram_dir, m_valid ? m_data : ram_sdi,
                (m_valid && m_ready) || (s_valid && s_ready));
      if (done) sb_take(EV_DONE, 1'b0, 64'd0, 1'b0);
    end
  end

  task automatic issue(input logic op, input int ff, input int ram);
    @(posedge clk); #1;
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_ff_words  = CW'(ff);
    cmd_ram_words = CW'(ram);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
  endtask

  // Runs from DRAIN to the FIN cycle, returning at the negedge that sees done.
  task automatic run_scan(input bit toggle_s, output int cyc, output int mv,
                          output int quiet, output int busy_bad);
    int  k;
    bit  hs;
    bit  fin;
    k = 0; cyc = 0; mv = 0; quiet = 0; busy_bad = 0; fin = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (m_valid) mv++;
      if (busy && !ff_scan && !ram_scan && !done) quiet++;
      if (cmd_ready || dut_clk_en || !pause || !busy) busy_bad++;
      hs = s_valid && s_ready;
      if (done) begin
        fin = 1;
      end else begin
        @(posedge clk); #1;
        if (hs) k++;
        if (toggle_s) begin
          s_valid = !s_valid;
          s_data  = ld_words[k % 8];
        end
      end
    end
    if (!fin) check("scan_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, mv, quiet, bb;
    for (int i = 0; i < 8; i++) ld_words[i] = 64'hC0DE_0000_0000_0000 + 64'(i * 17 + 3);

    // Reset state.
    @(negedge clk);
    check("reset_out", {58'd0, busy, pause, cmd_ready, done, m_valid, s_ready},
          64'b011000);
    check("reset_en", {61'd0, dut_clk_en, ff_clk_en, ram_clk_en}, 64'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    run_en = 1'b1;

    // Free-running emulation in IDLE: clock enables follow the stall.
    @(posedge clk); @(negedge clk);
    check("run_pause", 64'(pause), 64'd0);
    check("run_en_on", {61'd0, dut_clk_en, ff_clk_en, ram_clk_en}, 64'b111);
    @(posedge clk); #1 dut_stall = 1'b1;
    @(negedge clk);
    check("stall_en", {61'd0, dut_clk_en, ff_clk_en, ram_clk_en}, 64'b000);
    @(posedge clk); #1 dut_stall = 1'b0;
    @(negedge clk);
    check("unstall_en", 64'(dut_clk_en), 64'd1);
    @(posedge clk); #1 run_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("runoff_pause", {62'd0, pause, dut_clk_en}, 64'b10);
    @(posedge clk); #1 run_en = 1'b1;

    // Save 3 FF + 2 RAM words with the host always ready.
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(EV_FF, 1'b0, FF_WORD);
    for (int i = 0; i < 2; i++) push(EV_RAM, 1'b0, RAM_WORD);
    push(EV_DONE, 1'b0, 64'd0);
    issue(1'b0, 3, 2);
    run_scan(1'b0, cyc, mv, quiet, bb);
    check("save_cycles", 64'(cyc), 64'd8);
    check("save_mvalid", 64'(mv), 64'd5);
    check("save_quiet", 64'(quiet), 64'd2);
    check("save_busyctl", 64'(bb), 64'd0);
    @(posedge clk); @(negedge clk);
    check("after_fin", {61'd0, pause, busy, cmd_ready}, 64'b001);

    // Load 4 FF words, RAM empty, with s_valid toggling.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(EV_FF, 1'b1, ld_words[i]);
    push(EV_DONE, 1'b0, 64'd0);
    s_valid = 1'b1;
    s_data  = ld_words[0];
    issue(1'b1, 4, 0);
    run_scan(1'b1, cyc, mv, quiet, bb);
    s_valid = 1'b0;
    check("load_mvalid", 64'(mv), 64'd0);
    check("load_quiet", 64'(quiet), 64'd2);
    check("load_busyctl", 64'(bb), 64'd0);

    // Empty command: DRAIN then FIN, no chain clocks.
    push(EV_DONE, 1'b0, 64'd0);
    issue(1'b0, 0, 0);
    run_scan(1'b0, cyc, mv, quiet, bb);
    check("empty_cycles", 64'(cyc), 64'd2);
    check("empty_quiet", 64'(quiet), 64'd1);

    // Reset in the middle of a 10-word FF save, after 3 words.
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(EV_FF, 1'b0, FF_WORD);
    issue(1'b0, 10, 5);
    repeat (4) @(posedge clk);
    #1 m_ready = 1'b0;
    repeat (20) @(negedge clk);
    check("stall_hold", {61'd0, ff_scan, m_valid, ff_clk_en}, 64'b110);
    #2 rst = 1'b1;
    #1;
    check("midrst_out", {58'd0, busy, pause, ff_scan, ff_dir, m_valid, done}, 64'b010000);
    check("midrst_en", {61'd0, dut_clk_en, ff_clk_en, ram_clk_en}, 64'd0);
    check("midrst_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) push(EV_FF, 1'b0, FF_WORD);
    push(EV_RAM, 1'b0, RAM_WORD);
    push(EV_DONE, 1'b0, 64'd0);
    issue(1'b0, 2, 1);
    run_scan(1'b0, cyc, mv, quiet, bb);
    check("restart_cycles", 64'(cyc), 64'd6);
    check("restart_mvalid", 64'(mv), 64'd3);

    // cmd_valid held through a scan: second command taken only after done.
    push(EV_FF, 1'b0, FF_WORD);
    push(EV_RAM, 1'b0, RAM_WORD);
    push(EV_DONE, 1'b0, 64'd0);
    push(EV_DONE, 1'b0, 64'd0);
    @(posedge clk); #1;
    cmd_valid     = 1'b1;
    cmd_op        = 1'b0;
    cmd_ff_words  = CW'(1);
    cmd_ram_words = CW'(1);
    @(posedge clk); #1;
    cmd_op        = 1'b1;
    cmd_ff_words  = CW'(0);
    cmd_ram_words = CW'(0);
    run_scan(1'b0, cyc, mv, quiet, bb);
    check("held_cycles", 64'(cyc), 64'd5);
    check("held_busyctl", 64'(bb), 64'd0);
    @(posedge clk); @(negedge clk);
    check("held_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("held_accept", 64'(busy), 64'd1);
    run_scan(1'b0, cyc, mv, quiet, bb);
    check("held2_cycles", 64'(cyc), 64'd2);

    @(posedge clk); @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
